// File: rtl/permute_ctrl.sv
// Sequencer for the Spongent round core: runs ROUNDS core iterations per request,
// feeding each round's state and LFSR counter back, with a per-round response timeout.
module permute_ctrl #(
    parameter int unsigned   ROUNDS  = 140,
    parameter logic [15:0]   IV_INIT = 16'h009E,
    parameter int unsigned   TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [263:0]   state_in,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [263:0]   state_out,
    output logic [15:0]    round_cnt,
    output logic           rc_start,
    output logic [263:0]   rc_state,
    output logic [15:0]    rc_iv,
    input  logic           rc_rdy,
    input  logic [263:0]   rc_state_res,
    input  logic [15:0]    rc_iv_res
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [15:0]   ROUNDS_L = 16'(ROUNDS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    logic [2:0]    state_q,     state_d;
    logic [263:0]  rc_state_q,  rc_state_d;
    logic [15:0]   rc_iv_q,     rc_iv_d;
    logic [263:0]  state_out_q, state_out_d;
    logic [15:0]   round_cnt_q, round_cnt_d;
    logic [TW-1:0] to_q,        to_d;
    logic [15:0]   round_inc;

    assign round_inc = round_cnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        rc_state_d  = rc_state_q;
        rc_iv_d     = rc_iv_q;
        state_out_d = state_out_q;
        round_cnt_d = round_cnt_q;
        to_d        = to_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rc_state_d  = state_in;
                    rc_iv_d     = IV_INIT;
                    round_cnt_d = '0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                to_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the last allowed cycle still beats the timeout.
                if (rc_rdy) begin
                    rc_state_d  = rc_state_res;
                    rc_iv_d     = rc_iv_res;
                    round_cnt_d = round_inc;
                    if (round_inc == ROUNDS_L) begin
                        state_out_d = rc_state_res;
                        state_d     = S_FINISH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_FAULT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rc_state_q  <= '0;
            rc_iv_q     <= IV_INIT;
            state_out_q <= '0;
            round_cnt_q <= '0;
            to_q        <= '0;
        end else begin
            state_q     <= state_d;
            rc_state_q  <= rc_state_d;
            rc_iv_q     <= rc_iv_d;
            state_out_q <= state_out_d;
            round_cnt_q <= round_cnt_d;
            to_q        <= to_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign error     = (state_q == S_FAULT);
    assign rc_start  = (state_q == S_ISSUE);
    assign rc_state  = rc_state_q;
    assign rc_iv     = rc_iv_q;
    assign state_out = state_out_q;
    assign round_cnt = round_cnt_q;

endmodule

// File: tb/tb_permute_ctrl.sv
// Scoreboard bench for permute_ctrl: two instances (140 rounds and 1 round) driven by
// behavioural round-core stubs with programmable latency.
module tb_permute_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start        [2];
    logic [263:0]  state_in     [2];
    logic          busy         [2];
    logic          done         [2];
    logic          error        [2];
    logic [263:0]  state_out    [2];
    logic [15:0]   round_cnt    [2];
    logic          rc_start     [2];
    logic [263:0]  rc_state     [2];
    logic [15:0]   rc_iv        [2];
    logic          rc_rdy       [2];
    logic [263:0]  rc_state_res [2];
    logic [15:0]   rc_iv_res    [2];

    permute_ctrl #(.ROUNDS(140), .TIMEOUT(8)) u_dut_long (
        .clk(clk), .rst(rst), .start(start[0]), .state_in(state_in[0]),
        .busy(busy[0]), .done(done[0]), .error(error[0]), .state_out(state_out[0]),
        .round_cnt(round_cnt[0]), .rc_start(rc_start[0]), .rc_state(rc_state[0]),
        .rc_iv(rc_iv[0]), .rc_rdy(rc_rdy[0]), .rc_state_res(rc_state_res[0]),
        .rc_iv_res(rc_iv_res[0])
    );

    permute_ctrl #(.ROUNDS(1), .TIMEOUT(8)) u_dut_short (
        .clk(clk), .rst(rst), .start(start[1]), .state_in(state_in[1]),
        .busy(busy[1]), .done(done[1]), .error(error[1]), .state_out(state_out[1]),
        .round_cnt(round_cnt[1]), .rc_start(rc_start[1]), .rc_state(rc_state[1]),
        .rc_iv(rc_iv[1]), .rc_rdy(rc_rdy[1]), .rc_state_res(rc_state_res[1]),
        .rc_iv_res(rc_iv_res[1])
    );

    // Round-core stubs: respond lat cycles after rc_start; inc_mode returns state+1, iv^1.
    int            lat        [2];
    bit            inc_mode   [2];
    int            stop_after [2];
    int            served     [2] = '{0, 0};
    bit            pend       [2];
    int            dly        [2];
    logic          rdy_s      [2];
    logic [263:0]  res_st     [2];
    logic [15:0]   res_iv     [2];
    logic          frc_rdy    [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                rdy_s[k] <= 1'b0;
                pend[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                rdy_s[k] <= 1'b0;
                if (pend[k]) begin
                    if (dly[k] == 0) begin
                        rdy_s[k] <= 1'b1;
                        pend[k]  <= 1'b0;
                    end else begin
                        dly[k] <= dly[k] - 1;
                    end
                end
                if (rc_start[k] && (stop_after[k] < 0 || served[k] < stop_after[k])) begin
                    served[k] <= served[k] + 1;
                    res_st[k] <= inc_mode[k] ? rc_state[k] + 264'd1 : rc_state[k];
                    res_iv[k] <= inc_mode[k] ? rc_iv[k] ^ 16'h0001 : rc_iv[k];
                    if (lat[k] <= 1) begin
                        rdy_s[k] <= 1'b1;
                    end else begin
                        pend[k] <= 1'b1;
                        dly[k]  <= lat[k] - 2;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rc_rdy[k]       = rdy_s[k] | frc_rdy[k];
            rc_state_res[k] = frc_rdy[k] ? {264{1'b1}} : res_st[k];
            rc_iv_res[k]    = frc_rdy[k] ? 16'hFFFF : res_iv[k];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchecks = 0;
    int nerrors = 0;

    task automatic check(input int k, input string name, input logic [263:0] act,
                         input logic [263:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL [dut%0d] %s: got %0h expected %0h", k, name, act, exp);
        end
    endtask

    typedef struct {
        bit           is_err;
        logic [263:0] st;
        logic [15:0]  rc;
        int           cyc;
        int           nst;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   nst[2] = '{0, 0};

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int k);
        exp_t e;
        if (rst) begin
            nst[k] = 0;
        end else begin
            if (rc_start[k]) nst[k]++;
            if (done[k] || error[k]) begin
                if (qsize(k) == 0) begin
                    check(k, "resp_unexpected", {done[k], error[k]}, 0);
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    check(k, "resp_done",      done[k],      !e.is_err);
                    check(k, "resp_error",     error[k],     e.is_err);
                    check(k, "resp_state_out", state_out[k], e.st);
                    check(k, "resp_round_cnt", round_cnt[k], e.rc);
                    check(k, "resp_cycle",     cyc,          e.cyc);
                    check(k, "resp_rc_starts", nst[k],       e.nst);
                    check(k, "resp_busy",      busy[k],      1);
                end
                nst[k] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int k, input int budget);
        for (int i = 0; i < budget && qsize(k) != 0; i++) @(posedge clk);
        #1;
        check(k, "drain_pending", qsize(k), 0);
        if (k == 0) q0.delete();
        else        q1.delete();
    endtask

    task automatic chk_reset(input int k);
        check(k, "rst_busy",      busy[k],      0);
        check(k, "rst_done",      done[k],      0);
        check(k, "rst_error",     error[k],     0);
        check(k, "rst_rc_start",  rc_start[k],  0);
        check(k, "rst_state_out", state_out[k], 0);
        check(k, "rst_rc_state",  rc_state[k],  0);
        check(k, "rst_round_cnt", round_cnt[k], 0);
        check(k, "rst_rc_iv",     rc_iv[k],     16'h009E);
    endtask

    int           n;
    logic [263:0] a5, va, vb, vc;

    initial begin
        rst        = 1'b1;
        start      = '{1'b0, 1'b0};
        state_in   = '{264'd0, 264'd0};
        frc_rdy    = '{1'b0, 1'b0};
        lat        = '{2, 1};
        inc_mode   = '{1'b1, 1'b0};
        stop_after = '{-1, -1};
        a5 = {33{8'hA5}};
        va = {33{8'h3C}};
        vb = {33{8'hC6}};
        vc = {33{8'h71}};
        repeat (3) tick();
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        tick();

        // Asynchronous reset in the middle of a run, while waiting on round 6.
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int i = 0; i < 100 && round_cnt[0] != 16'd5; i++) tick();
        check(0, "mid_round_cnt", round_cnt[0], 5);
        tick();
        check(0, "mid_busy", busy[0], 1);
        #2 rst = 1'b1;
        #1 chk_reset(0);
        tick();
        rst = 1'b0;
        tick();

        // Full 140-round run, core latency 2.
        n = cyc;
        state_in[0] = '0;
        start[0] = 1'b1;
        push(0, '{1'b0, 264'd140, 16'd140, n + 421, 140});
        tick();
        start[0] = 1'b0;
        check(0, "first_rc_start", rc_start[0], 1);
        check(0, "first_rc_iv",    rc_iv[0],    16'h009E);
        check(0, "first_rc_state", rc_state[0], 0);
        wait_drain(0, 600);
        tick();
        check(0, "post_done_busy", busy[0], 0);

        // Core hangs after 3 rounds: error, state_out keeps the previous result.
        stop_after[0] = served[0] + 3;
        n = cyc;
        state_in[0] = vc;
        start[0] = 1'b1;
        push(0, '{1'b1, 264'd140, 16'd3, n + 19, 4});
        tick();
        start[0] = 1'b0;
        wait_drain(0, 100);
        tick();
        check(0, "post_err_busy", busy[0], 0);
        check(0, "post_err_done", done[0], 0);
        stop_after[0] = -1;

        // Single round, pass-through core, latency 1.
        n = cyc;
        state_in[1] = a5;
        start[1] = 1'b1;
        push(1, '{1'b0, a5, 16'd1, n + 3, 1});
        tick();
        start[1] = 1'b0;
        check(1, "r1_rc_start", rc_start[1], 1);
        check(1, "r1_rc_state", rc_state[1], a5);
        wait_drain(1, 50);

        // Spurious rc_rdy while idle.
        frc_rdy[1] = 1'b1;
        tick();
        frc_rdy[1] = 1'b0;
        tick();
        check(1, "spur_rc_state",  rc_state[1],  a5);
        check(1, "spur_rc_iv",     rc_iv[1],     16'h009E);
        check(1, "spur_round_cnt", round_cnt[1], 1);
        check(1, "spur_state_out", state_out[1], a5);
        check(1, "spur_busy",      busy[1],      0);

        // start held high across two runs: one capture per IDLE visit.
        n = cyc;
        state_in[1] = va;
        start[1] = 1'b1;
        push(1, '{1'b0, va, 16'd1, n + 3, 1});
        push(1, '{1'b0, vb, 16'd1, n + 7, 1});
        tick();
        state_in[1] = vb;
        repeat (7) tick();
        start[1] = 1'b0;
        wait_drain(1, 50);

        // Result lands on the final cycle before timeout.
        lat[1] = 8;
        n = cyc;
        state_in[1] = vc;
        start[1] = 1'b1;
        push(1, '{1'b0, vc, 16'd1, n + 10, 1});
        tick();
        start[1] = 1'b0;
        wait_drain(1, 50);

        repeat (3) tick();
        check(0, "final_queue", q0.size(), 0);
        check(1, "final_queue", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
